// File: rtl/add_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_arb_pkg
// Description : Shared definitions for the add_share_arbiter block.
//               Holds the default operand and counter widths and the
//               requester-id type.
// Revision    : 1.0 - initial release
// ============================================================================
package add_arb_pkg;

    localparam int WIDTH_DEF = 32;  // operand / sum width
    localparam int CNT_W_DEF = 16;  // accepted-operation counter width

    // Requester index: 0 or 1
    typedef logic id_t;

    localparam id_t ID_REQ0 = 1'b0;
    localparam id_t ID_REQ1 = 1'b1;

endpackage : add_arb_pkg
`default_nettype wire

// File: rtl/brent_kung_adder.sv
`default_nettype none
// ============================================================================
// Module      : brent_kung_adder
// Description : Purely combinational WIDTH-bit Brent-Kung parallel-prefix
//               adder. Carry-in is 0; the carry-out is not produced.
// Ports       : a   [WIDTH-1:0]  in   first operand
//               b   [WIDTH-1:0]  in   second operand
//               sum [WIDTH-1:0]  out  (a + b) mod 2^WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module brent_kung_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    // Largest power-of-two span used by the down-sweep.
    localparam int c_top_span = (WIDTH > 1) ? (1 << ($clog2(WIDTH) - 1)) : 1;

    always_comb begin
        logic [WIDTH-1:0] w_g;   // group generate, becomes prefix carry
        logic [WIDTH-1:0] w_p;   // group propagate
        logic [WIDTH-1:0] w_h;   // half-sum

        w_h = a ^ b;
        w_g = a & b;
        w_p = a ^ b;

        // Up-sweep: build power-of-two group terms at the odd-aligned nodes.
        for (int d = 1; d < WIDTH; d = d * 2) begin
            for (int i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - d]);
                w_p[i] = w_p[i] & w_p[i - d];
            end
        end

        // Down-sweep: fill in the remaining prefix nodes so w_g[i] is the
        // carry out of bits [i:0].
        for (int d = c_top_span; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - d]);
                w_p[i] = w_p[i] & w_p[i - d];
            end
        end

        sum    = w_h;
        for (int i = 1; i < WIDTH; i++) begin
            sum[i] = w_h[i] ^ w_g[i - 1];
        end
    end

endmodule : brent_kung_adder
`default_nettype wire

// File: rtl/add_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : add_share_arbiter
// Description : Two requesters share a single adder. A round-robin arbiter
//               grants one operand pair per cycle, the sum is registered
//               with valid/ready handshake, and accepted operations are
//               counted with saturation.
// Ports       : clk, rst                 clock, sync active-high reset
//               req0_valid/req1_valid    in   requester has operands
//               req0_ready/req1_ready    out  operands accepted this cycle
//               req0_a/b, req1_a/b       in   operands [WIDTH-1:0]
//               rsp_valid                out  result register valid
//               rsp_ready                in   consumer takes result
//               rsp_sum [WIDTH-1:0]      out  registered sum
//               rsp_id                   out  requester that produced it
//               op_count [CNT_W-1:0]     out  accepted ops, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module add_share_arbiter
    import add_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output id_t              rsp_id,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // State
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q,   rsp_sum_d;
    id_t              rsp_id_q,    rsp_id_d;
    id_t              last_q,      last_d;      // last accepted requester
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    // Arbitration / datapath
    logic             w_grant_valid;
    id_t              w_grant_id;
    logic             w_out_free;
    logic             w_accept;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;

    // Grant: a lone requester wins; on contention the one not accepted
    // most recently wins.
    always_comb begin
        w_grant_valid = req0_valid | req1_valid;
        w_grant_id    = ID_REQ0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~last_q;
        end else if (req1_valid) begin
            w_grant_id = ID_REQ1;
        end
    end

    // The result register can take a new pair when empty or draining now.
    assign w_out_free = ~rsp_valid_q | rsp_ready;
    assign w_accept   = w_grant_valid & w_out_free & ~rst;
    assign req0_ready = w_accept & (w_grant_id == ID_REQ0);
    assign req1_ready = w_accept & (w_grant_id == ID_REQ1);

    assign w_op_a = (w_grant_id == ID_REQ1) ? req1_a : req0_a;
    assign w_op_b = (w_grant_id == ID_REQ1) ? req1_b : req0_b;

    brent_kung_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a   (w_op_a),
        .b   (w_op_b),
        .sum (w_sum)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        last_d      = last_q;
        op_count_d  = op_count_q;

        if (w_accept) begin
            // Covers simultaneous drain+accept: valid stays high.
            rsp_valid_d = 1'b1;
            rsp_sum_d   = w_sum;
            rsp_id_d    = w_grant_id;
            last_d      = w_grant_id;
            if (op_count_q != c_cnt_max) begin
                op_count_d = op_count_q + CNT_W'(1);
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= ID_REQ0;
            last_q      <= ID_REQ1;   // requester 0 wins first contention
            op_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            last_q      <= last_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule : add_share_arbiter
`default_nettype wire

// File: tb/tb_add_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_share_arbiter
// Description : Self-checking bench for add_share_arbiter with directed
//               scenarios and randomized traffic compared against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_share_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_id;
    logic [CNT_W-1:0] op_count;

    add_share_arbiter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_id     (rsp_id),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the result register and counter should hold.
    bit      m_valid = 1'b0;
    longint  m_sum   = 0;
    int      m_id    = 0;
    int      m_last  = 1;      // index of last accepted requester
    int      m_cnt   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check handshake against the model,
    // clock, advance the model, then check registered outputs.
    task automatic step(input bit v0, input bit v1,
                        input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                        input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                        input bit rr, input bit rs);
        int     gid;
        bit     acc;
        longint s;
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        rsp_ready = rr; rst = rs;
        #1;
        if (v0 && v1) gid = 1 - m_last;
        else if (v1)  gid = 1;
        else          gid = 0;
        acc = !rs && (v0 || v1) && (!m_valid || rr);
        chk("req0_ready", req0_ready, (acc && gid == 0) ? 1 : 0);
        chk("req1_ready", req1_ready, (acc && gid == 1) ? 1 : 0);
        @(posedge clk);
        if (rs) begin
            m_valid = 0; m_sum = 0; m_id = 0; m_last = 1; m_cnt = 0;
        end else if (acc) begin
            s       = (gid == 1) ? (longint'(a1) + longint'(b1))
                                 : (longint'(a0) + longint'(b0));
            m_sum   = s % (64'd1 << WIDTH);
            m_id    = gid;
            m_valid = 1;
            m_last  = gid;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end else if (rr) begin
            m_valid = 0;
        end
        @(negedge clk);
        chk("rsp_valid", rsp_valid, m_valid);
        chk("rsp_sum",   rsp_sum,   m_sum);
        chk("rsp_id",    rsp_id,    m_id);
        chk("op_count",  op_count,  m_cnt);
    endtask

    task automatic idle(input bit rr);
        step(0, 0, '0, '0, '0, '0, rr, 0);
    endtask

    task automatic do_reset();
        step(1, 1, 32'd1, 32'd1, 32'd2, 32'd2, 1, 1);
        step(0, 0, '0, '0, '0, '0, 0, 1);
    endtask

    int exp_ids [4] = '{0, 1, 0, 1};

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Reset state
        do_reset();
        chk("reset_valid", rsp_valid, 0);
        chk("reset_cnt",   op_count,  0);

        // Single operation
        step(1, 0, 32'd5, 32'd7, '0, '0, 1, 0);
        chk("single_sum", rsp_sum, 12);
        chk("single_id",  rsp_id,  0);
        chk("single_cnt", op_count, 1);
        idle(1);
        chk("drained", rsp_valid, 0);

        // Contention, round robin 0,1,0,1
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 32'd10 + 32'(k), 32'd1, 32'd100 + 32'(k), 32'd1, 1, 0);
            chk("rr_id", rsp_id, exp_ids[k]);
            chk("rr_valid", rsp_valid, 1);
        end
        chk("rr_cnt", op_count, 4);

        // Backpressure: 0x10 held for 3 stalled cycles, pointer unchanged
        do_reset();
        step(1, 0, 32'h8, 32'h8, '0, '0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 32'h1, 32'h1, 32'h2, 32'h2, 0, 0);
            chk("stall_sum", rsp_sum, 32'h10);
        end
        step(1, 1, 32'h1, 32'h1, 32'h2, 32'h2, 1, 0);
        chk("post_stall_id", rsp_id, 1);

        // Overflow wraps
        step(0, 1, '0, '0, 32'hFFFF_FFFF, 32'h2, 1, 0);
        chk("ovf_sum", rsp_sum, 32'h1);
        chk("ovf_id",  rsp_id,  1);
        step(1, 0, 32'hFFFF_FFFF, 32'h1, '0, '0, 1, 0);
        chk("ovf_zero", rsp_sum, 0);

        // Reset mid-stall, then req0 wins contention
        step(0, 1, '0, '0, 32'h3, 32'h4, 0, 0);
        step(0, 0, '0, '0, '0, '0, 0, 1);
        chk("rst_stall_valid", rsp_valid, 0);
        chk("rst_stall_cnt",   op_count,  0);
        idle(0);
        chk("rst_no_output", rsp_valid, 0);
        step(1, 1, 32'h1, 32'h2, 32'h3, 32'h4, 1, 0);
        chk("rst_first_grant", rsp_id, 0);

        // Saturation: 20 back-to-back accepts
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1, 0, $urandom, $urandom, '0, '0, 1, 0);
        end
        chk("sat_cnt", op_count, 15);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom, $urandom, $urandom, $urandom,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 59) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_add_share_arbiter
`default_nettype wire

// File: doc/add_share_arbiter.md
ADD_SHARE_ARBITER -- requirements
Module: add_share_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/sum width in bits.
REQ-002 SHALL have parameter: CNT_W, 16, width of the accepted-operation counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports: req0_valid / req1_valid  input  1  requester 0 / 1 has an operand pair.
REQ-006 SHALL have ports: req0_ready / req1_ready  output  1  requester 0 / 1 operands accepted this cycle.
REQ-007 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands per requester.
REQ-008 SHALL have port: rsp_valid  output  1  result register holds a valid sum.
REQ-009 SHALL have port: rsp_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port: rsp_sum  output  WIDTH  (a+b) mod 2^WIDTH of the granted pair.
REQ-011 SHALL have port: rsp_id  output  1  requester index that produced rsp_sum.
REQ-012 SHALL have port: op_count  output  CNT_W  number of accepted operations, saturating.

Function
REQ-013 SHALL share one combinational WIDTH-bit adder between both requesters; carry-out discarded, carry-in 0.
REQ-014 SHALL accept requester i on a cycle where reqi_valid and reqi_ready are both 1.
REQ-015 SHALL assert at most one reqi_ready per cycle.
REQ-016 SHALL assert reqi_ready only when requester i is granted AND (rsp_valid==0 OR rsp_ready==1); combinational path rsp_ready->reqi_ready is permitted.
REQ-017 Grant: only one valid -> that one; both valid -> the requester NOT accepted most recently (round-robin); neither -> none.
REQ-018 SHALL update the round-robin pointer only on acceptance; a grant without acceptance (output stalled) leaves it unchanged.
REQ-019 SHALL load rsp_sum/rsp_id from the accepted pair and set rsp_valid at the next clock edge: latency 1 cycle.
REQ-020 SHALL hold rsp_sum, rsp_id, rsp_valid stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL clear rsp_valid when rsp_ready=1 and no acceptance occurs in the same cycle.
REQ-022 Simultaneous drain and accept: rsp_valid stays 1, register loads new pair; sustained throughput 1 op/cycle.
REQ-023 SHALL increment op_count by 1 per acceptance and saturate at 2^CNT_W-1 (no wrap).
REQ-024 Operands with overflow (e.g. 0xFFFFFFFF+1) SHALL produce wrapped sum (0x00000000), no flag.
REQ-025 SHALL not require requesters to hold operands stable beyond the accepting cycle.

Reset
REQ-026 On rst=1 at a clock edge: rsp_valid=0, rsp_sum=0, rsp_id=0, op_count=0.
REQ-027 On reset the round-robin pointer SHALL mark requester 1 as last accepted, so requester 0 wins the first contended grant.
REQ-028 While rst=1, req0_ready and req1_ready SHALL be 0; an in-flight result is discarded.
REQ-029 Reset mid-stall SHALL drop the pending result; no output after reset until a new acceptance.

Structure
REQ-030 Package add_arb_pkg SHALL hold WIDTH default, CNT_W default, and the requester-id typedef (1 bit).
REQ-031 SHALL instantiate the existing brent_kung_adder as the single shared adder sub-module, fed by a 2:1 operand mux on the grant.
REQ-032 Arbiter, output register and counter SHALL be local logic in add_share_arbiter; no further sub-modules.

Verification
REQ-033 Single op: req0 a=5,b=7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=12, rsp_id=0, op_count=1.
REQ-034 Contention: both valid 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1; op_count=4; one result per cycle.
REQ-035 Backpressure: rsp_ready=0 for 3 cycles with result 0x10 held -> rsp_sum stays 0x10, both readies 0, pointer unchanged; on rsp_ready=1 the next grant follows REQ-017.
REQ-036 Overflow: req1 a=0xFFFFFFFF,b=0x00000002 -> rsp_sum=0x00000001, rsp_id=1.
REQ-037 Reset mid-stall: rsp_valid=1, rsp_ready=0, pulse rst 1 cycle -> rsp_valid=0, op_count=0; next contended grant goes to req0.
REQ-038 Saturation: CNT_W=4, 20 back-to-back accepts -> op_count stops at 15.
